// File: rtl/mem_wb_pipe_reg_pkg.sv
// Shared types and default widths for the MEM->WB pipeline register.
package mem_wb_pipe_reg_pkg;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_WORD_W    = 32;
    localparam int DEF_REG_IDX_W = 4;
    localparam int DEF_CNT_W     = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    // Entry layout at the default widths; the top rebuilds it from its own parameters.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0]    pc;
        logic [DEF_ADDR_W-1:0]    alu_res;
        logic [DEF_WORD_W-1:0]    mem_data;
        logic                     mem_r_en;
        logic                     wb_en;
        logic [DEF_REG_IDX_W-1:0] dest;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/mem_wb_pipe_reg_pipe_entry_reg.sv
// Load-enabled register holding one pipeline entry, cleared by synchronous reset.
module pipe_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: payload is cleared on reset so wb_value reads zero before the first entry arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register: valid/ready handshake with a one-entry skid, flush,
// writeback-value selection, forwarding taps and a retired-instruction counter.
module mem_wb_pipe_reg
    import mem_wb_pipe_reg_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int WORD_W    = DEF_WORD_W,
    parameter int REG_IDX_W = DEF_REG_IDX_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_W-1:0]    pc_in,
    input  logic [ADDR_W-1:0]    alu_res_in,
    input  logic [WORD_W-1:0]    mem_data_in,
    input  logic                 mem_r_en_in,
    input  logic                 wb_en_in,
    input  logic [REG_IDX_W-1:0] dest_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_W-1:0]    pc_out,
    output logic [ADDR_W-1:0]    alu_res_out,
    output logic [WORD_W-1:0]    mem_data_out,
    output logic                 mem_r_en_out,
    output logic                 wb_en_out,
    output logic [REG_IDX_W-1:0] dest_out,
    output logic [WORD_W-1:0]    wb_value,
    output logic                 fwd_valid,
    output logic [REG_IDX_W-1:0] fwd_dest,
    output logic [WORD_W-1:0]    fwd_value,
    output logic [CNT_W-1:0]     retired_count
);

    typedef struct packed {
        logic [ADDR_W-1:0]    pc;
        logic [ADDR_W-1:0]    alu_res;
        logic [WORD_W-1:0]    mem_data;
        logic                 mem_r_en;
        logic                 wb_en;
        logic [REG_IDX_W-1:0] dest;
    } pipe_entry_t;

    localparam int PIPE_ENTRY_W = $bits(pipe_entry_t);

    state_e      state_q;
    pipe_entry_t in_entry;
    pipe_entry_t main_d;
    pipe_entry_t main_q;
    pipe_entry_t skid_q;
    logic        in_fire;
    logic        out_fire;
    logic        main_load;
    logic        skid_load;
    logic [WORD_W-1:0] alu_res_wb;

    // Handshake decodes depend on the state register only, so out_ready never reaches in_ready.
    assign in_ready  = (state_q != SKID);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign in_entry = '{
        pc:       pc_in,
        alu_res:  alu_res_in,
        mem_data: mem_data_in,
        mem_r_en: mem_r_en_in,
        wb_en:    wb_en_in,
        dest:     dest_in
    };

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_entry;
        case (state_q)
            EMPTY: main_load = in_fire;
            FULL: begin
                main_load = in_fire & out_fire;
                skid_load = in_fire & ~out_fire;
            end
            SKID: begin
                main_load = out_fire;
                main_d    = skid_q;
            end
            default: ;
        endcase
    end

    pipe_entry_reg #(.W(PIPE_ENTRY_W)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    pipe_entry_reg #(.W(PIPE_ENTRY_W)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (in_entry),
        .q    (skid_q)
    );

    // A flush empties the buffer but a head consumed in the same cycle still retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= EMPTY;
            retired_count <= '0;
        end else begin
            if (out_fire) begin
                retired_count <= retired_count + CNT_W'(1);
            end
            if (flush) begin
                state_q <= EMPTY;
            end else begin
                case (state_q)
                    EMPTY: if (in_fire) state_q <= FULL;
                    FULL: begin
                        if (in_fire && !out_fire) begin
                            state_q <= SKID;
                        end else if (!in_fire && out_fire) begin
                            state_q <= EMPTY;
                        end
                    end
                    SKID: if (out_fire) state_q <= FULL;
                    default: state_q <= EMPTY;
                endcase
            end
        end
    end

    generate
        if (ADDR_W >= WORD_W) begin : g_alu_trunc
            assign alu_res_wb = main_q.alu_res[WORD_W-1:0];
        end else begin : g_alu_ext
            assign alu_res_wb = {{(WORD_W-ADDR_W){1'b0}}, main_q.alu_res};
        end
    endgenerate

    assign pc_out       = main_q.pc;
    assign alu_res_out  = main_q.alu_res;
    assign mem_data_out = main_q.mem_data;
    assign mem_r_en_out = main_q.mem_r_en;
    assign wb_en_out    = main_q.wb_en;
    assign dest_out     = main_q.dest;

    assign wb_value  = main_q.mem_r_en ? main_q.mem_data : alu_res_wb;
    assign fwd_valid = out_valid & main_q.wb_en;
    assign fwd_dest  = main_q.dest;
    assign fwd_value = wb_value;

endmodule

// File: doc/mem_wb_pipe_reg.md
Name: mem_wb_pipe_reg

Overview:
- Parametrised MEM->WB pipeline register.
- Adds a valid/ready handshake, a 2-entry skid buffer, synchronous flush, writeback-value selection, forwarding outputs and a retired-instruction counter.
- Sits between the memory stage and the writeback/register-file stage.
- Lets a multi-cycle writeback or register-file port backpressure the memory stage without losing data.

Parameters:
- ADDR_W, 32, width of pc and ALU result.
- WORD_W, 32, width of memory read data and writeback value.
- REG_IDX_W, 4, width of destination register index.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  memory stage presents an entry.
- in_ready  out  1  block can accept an entry this cycle.
- pc_in  in  ADDR_W  instruction pc.
- alu_res_in  in  ADDR_W  ALU result / address.
- mem_data_in  in  WORD_W  memory read data.
- mem_r_en_in  in  1  entry is a load.
- wb_en_in  in  1  entry writes the register file.
- dest_in  in  REG_IDX_W  destination register.
- out_valid  out  1  head entry valid.
- out_ready  in  1  writeback consumes the head this cycle.
- pc_out, alu_res_out, mem_data_out, mem_r_en_out, wb_en_out, dest_out  out  as inputs  head entry fields.
- wb_value  out  WORD_W  mem_r_en_out ? mem_data_out : alu_res_out (zero-extended or truncated to WORD_W).
- fwd_valid  out  1  out_valid & wb_en_out.
- fwd_dest  out  REG_IDX_W  = dest_out.
- fwd_value  out  WORD_W  = wb_value.
- retired_count  out  CNT_W  number of consumed entries.

Behaviour:
- One clock, clk; reset is synchronous and active-high, rst.
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- State machine:
  - States: EMPTY (no entries), FULL (main only), SKID (main + skid).
  - in_ready = (state != SKID), combinational from state only; no combinational path from out_ready.
  - out_valid = (state != EMPTY).
  - Outputs are always driven from the main register.
- Transitions:
  - EMPTY: in_fire -> FULL, main <= in.
  - FULL:
    - in_fire & out_fire -> FULL, main <= in.
    - out_fire only -> EMPTY.
    - in_fire only -> SKID, skid <= in.
  - SKID (in_ready = 0): out_fire -> FULL, main <= skid; otherwise hold.
- Latency: 1 cycle from in_fire to out_valid when EMPTY.
- Throughput: 1 entry per cycle while out_ready stays high.
- Ordering is strictly FIFO.
- rst: state <= EMPTY, all payload registers <= 0, retired_count <= 0.
  - After reset: out_valid = 0, in_ready = 1, fwd_valid = 0, wb_value = 0.
- flush (lower priority than rst):
  - Next state is EMPTY; payload registers are not required to clear.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts as consumed.
- retired_count increments by 1 on every out_fire and wraps modulo 2^CNT_W.
- Forwarding covers the main entry only. While in_ready = 0, the upstream hazard unit stalls, so the skid entry is never a forwarding source.
- Payload may be X when valid = 0. Bench checks fields only when out_valid = 1.

Decomposition:
- Shared package: the three state encodings (2-bit localparams EMPTY = 0, FULL = 1, SKID = 2) and a packed entry struct {pc, alu_res, mem_data, mem_r_en, wb_en, dest}, width sum as a constant.
- Width defaults come from the global config defines.
- One natural sub-module: pipe_entry_reg, a parametrised register of entry width with synchronous reset and load enable. It is instantiated twice, for main and skid.

Test Plan:
- Reset then idle: rst high 2 cycles -> out_valid = 0, in_ready = 1, retired_count = 0, wb_value = 0.
- Streaming: out_ready = 1, 4 entries with pc = 0x10, 0x14, 0x18, 0x1C on consecutive cycles -> same pcs appear one cycle later, in order; retired_count = 4.
- Backpressure: out_ready = 0, push A (pc = 0x20) and B (pc = 0x24).
  - After B: in_ready = 0; C held by upstream.
  - Raise out_ready -> A, B, C out in order, no loss or duplication.
- WB select, load entry: mem_r_en = 1, mem_data = 0xDEADBEEF, alu_res = 0x100 -> wb_value = 0xDEADBEEF.
- WB select, ALU entry: mem_r_en = 0, alu_res = 0x100 -> wb_value = 0x100.
- Forwarding: wb_en = 1, dest = 5 -> fwd_valid = 1, fwd_dest = 5. With wb_en = 0 -> fwd_valid = 0.
- Flush in SKID with simultaneous in_valid -> next cycle out_valid = 0, in_ready = 1, incoming entry dropped, retired_count unchanged unless out_fire occurred that cycle.
- rst asserted in FULL -> next cycle EMPTY and retired_count = 0.
